integration_file_unit: RTL and testbench
========================================

Name: integration_file_unit

Overview:
- Discrete trapezoidal integrator, two-stage pipeline.
- Each clock, takes two unsigned samples A and B and computes the trapezoid step floor((A+B)/2).
- Adds the step to a running accumulator, driven out on R.
- Used as a leaf datapath block behind Avalon-style conduit ports (coe_*) with clock/reset sinks (csi_/rsi_).

Parameters:
- N, default 32, data width of A, B, R and the accumulator (N >= 2).

Ports:
- csi_clk  input  1  single system clock, rising-edge active
- rsi_srst  input  1  reset; asynchronous assert, active-low (0 = reset); release is synchronised externally
- coe_A  input  N  unsigned sample A
- coe_B  input  N  unsigned sample B
- coe_R  output  N  unsigned accumulated integral, registered

Behaviour:
- Reset:
  - While rsi_srst = 0, a_q, b_q and acc clear to 0 immediately, without waiting for a clock edge.
  - coe_R = 0 during reset.
- Stage 1, every rising edge out of reset: a_q <= coe_A, b_q <= coe_B.
- Step computation, combinational from stage-1 registers:
  - sum = {1'b0,a_q} + {1'b0,b_q}, N+1 bits, no overflow.
  - step = sum[N:1], i.e. floor((a_q+b_q)/2), N bits.
- Stage 2, every rising edge out of reset: acc <= acc + step, modulo 2^N (wrap-around, carry dropped).
- Output: coe_R = acc, driven directly from the register with no combinational path from the inputs.
- Latency:
  - An input sampled at edge k contributes to coe_R after edge k+1.
  - Inputs held for p cycles are accumulated p times.
- The accumulator runs on every clock; there is no enable and no clear other than reset.
- All arithmetic is unsigned.
- X-free reset state for every register.
- Reset mid-operation: all registers clear at once. After release, the first edge loads stage 1 from the current inputs, and coe_R starts changing at the second edge.

Optional Feature:
- Macro INTEGRATION_FILE_SATURATE_EN.
- When defined:
  - Accumulation uses an N+1-bit sum.
  - If the carry is set, acc <= all-ones (2^N-1); otherwise acc <= the low N bits.
  - Once saturated, acc stays at all-ones until reset.
- When undefined: modulo-2^N wrap as described above.

Decomposition:
- Package integration_file_pkg holds:
  - constant DEFAULT_N = 32
  - function trap_step(a,b), returning floor((a+b)/2) without overflow
  - function sat_add(acc,step)
- One natural sub-module, integration_file_step: stage-1 registers plus the trapezoid-step combinational logic, outputting step.
- The top level holds the accumulator and the output.

Test Plan:
- Reset: rsi_srst=0 with A=7, B=9 -> coe_R=0 without waiting for a clock edge; stays 0 while reset is held.
- Constant inputs: release reset, A=4, B=6 held -> coe_R=0 after edge 1, 5 after edge 2, 10 after edge 3, 15 after edge 4.
- Odd sum truncation: reset, then A=3, B=0 held -> coe_R sequence 0, 1, 2, 3.
- Overflow-free step: N=32, reset, A=B=32'hFFFFFFFF for one cycle, then A=B=0 -> step is 32'hFFFFFFFF; coe_R=32'hFFFFFFFF two edges after release.
- Wrap-around: continue one more cycle with A=B=2 (step 2):
  - macro undefined -> coe_R=1
  - with INTEGRATION_FILE_SATURATE_EN -> coe_R=32'hFFFFFFFF and it holds.
- Reset mid-operation: accumulate A=10, B=10 to coe_R=30, assert rsi_srst=0 between edges -> coe_R=0 immediately; release with A=2, B=2 -> 0 after edge 1, 2 after edge 2.

Source files
------------

// File: rtl/integration_file_pkg.sv
// Shared constants and arithmetic helpers for the trapezoidal integrator.
// Helpers operate on a MAX_W-bit word; callers zero-extend N-bit operands (N <= MAX_W).
package integration_file_pkg;

  localparam int unsigned DEFAULT_N = 32;
  localparam int unsigned MAX_W     = 64;

  typedef logic [MAX_W-1:0] word_t;

  // floor((a+b)/2) computed without needing a carry bit beyond the operand width
  function automatic word_t trap_step(input word_t a, input word_t b);
    return (a >> 1) + (b >> 1) + {{(MAX_W-1){1'b0}}, a[0] & b[0]};
  endfunction

  // Saturating add clamped to the all-ones value of a 'width'-bit word
  function automatic word_t sat_add(input word_t acc, input word_t step,
                                    input int unsigned width);
    logic [MAX_W:0] sum;
    word_t          lim;
    sum = {1'b0, acc} + {1'b0, step};
    if (width >= MAX_W) lim = '1;
    else                lim = (word_t'(1) << width) - word_t'(1);
    if (sum > {1'b0, lim}) return lim;
    else                   return sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/integration_file_step.sv
// Stage 1 of the integrator: input sample registers and the trapezoid step.
module integration_file_step
  import integration_file_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         csi_clk,
  input  logic         rsi_srst,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] step_o
);

  logic [N-1:0] a_q, b_q;
  word_t        a_ext, b_ext, step_w;

  always_ff @(posedge csi_clk or negedge rsi_srst) begin
    if (!rsi_srst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  always_comb begin
    a_ext          = '0;
    b_ext          = '0;
    a_ext[N-1:0]   = a_q;
    b_ext[N-1:0]   = b_q;
    step_w         = trap_step(a_ext, b_ext);
  end

  assign step_o = step_w[N-1:0];

  // Upper bits of the wide helper result are always zero for N-bit operands
  if (N < MAX_W) begin : g_sink
    logic unused_hi;
    assign unused_hi = ^step_w[MAX_W-1:N];
  end

endmodule

// File: rtl/integration_file_unit.sv
// Two-stage discrete trapezoidal integrator; accumulator and registered output.
// Optional build macro INTEGRATION_FILE_SATURATE_EN clamps the accumulator at all-ones.
module integration_file_unit
  import integration_file_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         csi_clk,
  input  logic         rsi_srst,
  input  logic [N-1:0] coe_A,
  input  logic [N-1:0] coe_B,
  output logic [N-1:0] coe_R
);

  logic [N-1:0] step;
  logic [N-1:0] acc_q, acc_d;

  integration_file_step #(.N(N)) u_step (
    .csi_clk  (csi_clk),
    .rsi_srst (rsi_srst),
    .a_i      (coe_A),
    .b_i      (coe_B),
    .step_o   (step)
  );

`ifdef INTEGRATION_FILE_SATURATE_EN
  word_t acc_ext, step_ext, sat_w;

  always_comb begin
    acc_ext         = '0;
    step_ext        = '0;
    acc_ext[N-1:0]  = acc_q;
    step_ext[N-1:0] = step;
    sat_w           = sat_add(acc_ext, step_ext, N);
    acc_d           = sat_w[N-1:0];
  end

  if (N < MAX_W) begin : g_sat_sink
    logic unused_sat_hi;
    assign unused_sat_hi = ^sat_w[MAX_W-1:N];
  end
`else
  always_comb begin
    acc_d = acc_q + step;
  end
`endif

  always_ff @(posedge csi_clk or negedge rsi_srst) begin
    if (!rsi_srst) acc_q <= '0;
    else           acc_q <= acc_d;
  end

  assign coe_R = acc_q;

endmodule

// File: tb/tb_integration_file_unit.sv
// Directed, table-driven bench for integration_file_unit (N = 32).
module tb_integration_file_unit;

  localparam int unsigned N = 32;

  logic         csi_clk;
  logic         rsi_srst;
  logic [N-1:0] coe_A, coe_B;
  logic [N-1:0] coe_R;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string        name;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_r;
  } vec_t;

  vec_t vecs[$];

  integration_file_unit #(.N(N)) dut (
    .csi_clk  (csi_clk),
    .rsi_srst (rsi_srst),
    .coe_A    (coe_A),
    .coe_B    (coe_B),
    .coe_R    (coe_R)
  );

  initial csi_clk = 1'b0;
  always #5 csi_clk = ~csi_clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input string name, input logic rst_n,
                              input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [N-1:0] exp_r);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.a = a; v.b = b; v.exp_r = exp_r;
    vecs.push_back(v);
  endfunction

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge
  task automatic apply(input logic rst_n, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge csi_clk);
    rsi_srst = rst_n;
    coe_A    = a;
    coe_B    = b;
    @(posedge csi_clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] wrap1, wrap2, wrap3;
`ifdef INTEGRATION_FILE_SATURATE_EN
    wrap1 = 32'hFFFF_FFFF; wrap2 = 32'hFFFF_FFFF; wrap3 = 32'hFFFF_FFFF;
`else
    wrap1 = 32'd1;         wrap2 = 32'd3;         wrap3 = 32'd5;
`endif

    add("const_e1",  1'b1, 32'd4, 32'd6, 32'd0);
    add("const_e2",  1'b1, 32'd4, 32'd6, 32'd5);
    add("const_e3",  1'b1, 32'd4, 32'd6, 32'd10);
    add("const_e4",  1'b1, 32'd4, 32'd6, 32'd15);
    add("odd_rst",   1'b0, 32'd3, 32'd0, 32'd0);
    add("odd_e1",    1'b1, 32'd3, 32'd0, 32'd0);
    add("odd_e2",    1'b1, 32'd3, 32'd0, 32'd1);
    add("odd_e3",    1'b1, 32'd3, 32'd0, 32'd2);
    add("odd_e4",    1'b1, 32'd3, 32'd0, 32'd3);
    add("mix_rst",   1'b0, 32'd5, 32'd8, 32'd0);
    add("mix_e1",    1'b1, 32'd5, 32'd8, 32'd0);
    add("mix_e2",    1'b1, 32'd5, 32'd8, 32'd6);
    add("mix_e3",    1'b1, 32'd5, 32'd8, 32'd12);
    add("max_rst",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    add("max_e1",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    add("max_e2",    1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF);
    add("max_e3",    1'b1, 32'd2, 32'd2, 32'hFFFF_FFFF);
    add("wrap_e4",   1'b1, 32'd2, 32'd2, wrap1);
    add("wrap_e5",   1'b1, 32'd2, 32'd2, wrap2);
    add("wrap_e6",   1'b1, 32'd2, 32'd2, wrap3);

    rsi_srst = 1'b1;
    coe_A    = '0;
    coe_B    = '0;

    // Asynchronous reset before any clock edge
    #1;
    rsi_srst = 1'b0;
    coe_A    = 32'd7;
    coe_B    = 32'd9;
    #1;
    check("rst_async", coe_R, 32'd0);
    @(posedge csi_clk); #1;
    check("rst_hold1", coe_R, 32'd0);
    @(posedge csi_clk); #1;
    check("rst_hold2", coe_R, 32'd0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].a, vecs[i].b);
      check(vecs[i].name, coe_R, vecs[i].exp_r);
    end

    // Reset mid-operation, asserted between edges
    apply(1'b0, 32'd10, 32'd10);
    check("mid_rst0", coe_R, 32'd0);
    apply(1'b1, 32'd10, 32'd10);
    check("mid_e1", coe_R, 32'd0);
    apply(1'b1, 32'd10, 32'd10);
    check("mid_e2", coe_R, 32'd10);
    apply(1'b1, 32'd10, 32'd10);
    check("mid_e3", coe_R, 32'd20);
    apply(1'b1, 32'd10, 32'd10);
    check("mid_e4", coe_R, 32'd30);
    @(negedge csi_clk);
    #2;
    rsi_srst = 1'b0;
    #1;
    check("mid_async", coe_R, 32'd0);
    apply(1'b0, 32'd10, 32'd10);
    check("mid_held", coe_R, 32'd0);
    apply(1'b1, 32'd2, 32'd2);
    check("rel_e1", coe_R, 32'd0);
    apply(1'b1, 32'd2, 32'd2);
    check("rel_e2", coe_R, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
